// File: rtl/ccff_bitstream_loader.sv
// Configuration-chain writer: takes bitstream words on a valid/ready stream and shifts them
// MSB-first into the ccff chain. An optional verify pass compares ccff_tail against the resent stream.
module ccff_bitstream_loader #(
  parameter int WORD_WIDTH = 32,
  parameter int CHAIN_LEN  = 4096,
  parameter int CNT_W      = $clog2(CHAIN_LEN + 1)
) (
  input  logic                  prog_clk,
  input  logic                  prog_reset_n,
  input  logic                  start,
  input  logic                  verify,
  input  logic                  abort,
  input  logic [WORD_WIDTH-1:0] word_data,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic                  ccff_head,
  input  logic                  ccff_tail,
  output logic                  ccff_shift_en,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [CNT_W-1:0]      bit_count,
  output logic [1:0]            dbg_state_o
);

  localparam int NWORDS = (CHAIN_LEN + WORD_WIDTH - 1) / WORD_WIDTH;
  localparam int WCNT_W = $clog2(NWORDS + 1);
  localparam int BL_W   = $clog2(WORD_WIDTH + 1);
  localparam int REM    = CHAIN_LEN % WORD_WIDTH;
  localparam logic [BL_W-1:0]   FULL_BITS    = BL_W'(WORD_WIDTH);
  localparam logic [BL_W-1:0]   LAST_BITS    = BL_W'((REM == 0) ? WORD_WIDTH : REM);
  localparam logic [WCNT_W-1:0] WORDS_MAX    = WCNT_W'(NWORDS);
  localparam logic [CNT_W-1:0]  LAST_BIT_IDX = CNT_W'(CHAIN_LEN - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FLUSH = 2'd2} state_t;

  // Handshake: a word transfers on a prog_clk edge where word_valid and word_ready are both 1;
  // word_ready depends only on registers, and the host must hold word_data until it transfers.
  state_t                state_q, state_d;
  logic [WORD_WIDTH-1:0] sreg_q, skid_q;
  logic [BL_W-1:0]       bits_left_q, skid_bits_q;
  logic                  skid_valid_q;
  logic [WCNT_W-1:0]     words_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  verify_q, error_q, done_q;

  logic start_ok, accept, last_shift, sreg_last, load, to_idle;

  assign start_ok   = (state_q == S_IDLE) && start && !abort;
  assign accept     = word_valid && word_ready;
  assign last_shift = ccff_shift_en && (cnt_q == LAST_BIT_IDX);
  // sreg is free for the next word once its last bit leaves on this edge
  assign sreg_last  = (bits_left_q == '0) || (ccff_shift_en && (bits_left_q == BL_W'(1)));
  assign load       = sreg_last && skid_valid_q;
  assign to_idle    = busy && (abort || last_shift);

  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) state_q <= S_IDLE;
    else               state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_ok) state_d = S_RUN;
      S_RUN: begin
        if (abort)                                            state_d = S_IDLE;
        else if (accept && (words_q == WORDS_MAX - WCNT_W'(1))) state_d = S_FLUSH;
      end
      S_FLUSH: if (abort || last_shift) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy          = (state_q != S_IDLE);
    word_ready    = (state_q == S_RUN) && !skid_valid_q && (words_q < WORDS_MAX);
    ccff_shift_en = busy && (bits_left_q != '0);
  end

  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      sreg_q       <= '0;
      skid_q       <= '0;
      bits_left_q  <= '0;
      skid_bits_q  <= '0;
      skid_valid_q <= 1'b0;
      words_q      <= '0;
      cnt_q        <= '0;
      verify_q     <= 1'b0;
      error_q      <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= (state_q == S_FLUSH) && last_shift && !abort;
      if (start_ok) begin
        verify_q <= verify;
        error_q  <= 1'b0;
        cnt_q    <= '0;
        words_q  <= '0;
      end
      if (ccff_shift_en) begin
        sreg_q      <= sreg_q << 1;
        bits_left_q <= bits_left_q - BL_W'(1);
        cnt_q       <= cnt_q + CNT_W'(1);
        if (verify_q && (ccff_tail != ccff_head)) error_q <= 1'b1;
      end
      if (accept) begin
        skid_q       <= word_data;
        skid_valid_q <= 1'b1;
        skid_bits_q  <= (words_q == WORDS_MAX - WCNT_W'(1)) ? LAST_BITS : FULL_BITS;
        words_q      <= words_q + WCNT_W'(1);
      end
      if (load) begin
        sreg_q       <= skid_q;
        bits_left_q  <= skid_bits_q;
        skid_valid_q <= 1'b0;
      end
      // Leaving the pass drops any buffered data so the next pass starts clean
      if (to_idle) begin
        sreg_q       <= '0;
        bits_left_q  <= '0;
        skid_valid_q <= 1'b0;
      end
    end
  end

  assign ccff_head   = sreg_q[WORD_WIDTH-1];
  assign bit_count   = cnt_q;
  assign done        = done_q;
  assign error       = error_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Directed bench for ccff_bitstream_loader with a 20-FF chain model (WORD_WIDTH=8, CHAIN_LEN=20);
// a bit-level scoreboard checks every shifted head bit against the words handed over.
module tb_ccff_bitstream_loader;
  localparam int W = 8;
  localparam int L = 20;

  logic         prog_clk = 1'b0;
  logic         prog_reset_n;
  logic         start, verify, abort;
  logic [W-1:0] word_data;
  logic         word_valid;
  logic         word_ready, ccff_head, ccff_tail, ccff_shift_en;
  logic         busy, done, error;
  logic [4:0]   bit_count;
  logic [1:0]   dbg_state_o;
  logic [L-1:0] chain;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int shifts, first_cyc, last_cyc, done_seen, pushed;
  logic [0:0] exp_q[$];

  ccff_bitstream_loader #(.WORD_WIDTH(W), .CHAIN_LEN(L)) dut (
    .prog_clk(prog_clk), .prog_reset_n(prog_reset_n), .start(start), .verify(verify),
    .abort(abort), .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
    .ccff_head(ccff_head), .ccff_tail(ccff_tail), .ccff_shift_en(ccff_shift_en),
    .busy(busy), .done(done), .error(error), .bit_count(bit_count), .dbg_state_o(dbg_state_o)
  );

  // clock / chain model
  always #5 prog_clk = ~prog_clk;

  always @(posedge prog_clk) begin
    if (ccff_shift_en) chain <= {chain[L-2:0], ccff_head};
  end
  assign ccff_tail = chain[L-1];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one cycle: scoreboard runs at the negedge, control returns 1 time unit after the posedge
  task automatic tick();
    logic [0:0] e;
    @(negedge prog_clk);
    cyc++;
    if (done) done_seen++;
    if (ccff_shift_en) begin
      shifts++;
      if (first_cyc < 0) first_cyc = cyc;
      last_cyc = cyc;
      if (exp_q.size() == 0) check("unexpected_shift", 32'(ccff_shift_en), 32'd0);
      else begin
        e = exp_q.pop_front();
        check("head_bit", 32'(ccff_head), 32'(e));
      end
    end
    @(posedge prog_clk);
    #1;
  endtask

  task automatic start_pass(input logic v);
    shifts = 0; first_cyc = -1; last_cyc = -1; done_seen = 0; pushed = 0;
    exp_q.delete();
    start = 1'b1; verify = v;
    tick();
    start = 1'b0; verify = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic send_word(input logic [W-1:0] w);
    int n = 0;
    word_data = w; word_valid = 1'b1;
    while (!word_ready && n < 40) begin tick(); n++; end
    if (!word_ready) check("word_ready_timeout", 32'(word_ready), 32'd1);
    else begin
      tick();
      for (int b = W - 1; b >= 0; b--) begin
        if (pushed < L) begin exp_q.push_back(w[b]); pushed++; end
      end
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 80) begin tick(); n++; end
    check("pass_ends", 32'(busy), 32'd0);
    tick(); tick();
  endtask

  task automatic wait_count(input int t);
    int n = 0;
    while (bit_count != 5'(t) && n < 60) begin tick(); n++; end
    check("reach_bit_count", 32'(bit_count), 32'(t));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_word_ready"}, 32'(word_ready), 32'd0);
    check({tag, "_head"}, 32'(ccff_head), 32'd0);
    check({tag, "_shift_en"}, 32'(ccff_shift_en), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
    check({tag, "_bit_count"}, 32'(bit_count), 32'd0);
  endtask

  task automatic program_full(input logic [W-1:0] w2);
    send_word(8'hA5); send_word(8'h3C); send_word(w2);
    word_valid = 1'b0;
    wait_idle();
  endtask

  initial begin
    int n;
    prog_reset_n = 1'b0; start = 1'b0; verify = 1'b0; abort = 1'b0;
    word_data = '0; word_valid = 1'b0;
    shifts = 0; first_cyc = -1; last_cyc = -1; done_seen = 0; pushed = 0;
    repeat (3) tick();
    check_reset_outputs("reset");
    prog_reset_n = 1'b1;
    tick();

    // 1: back-to-back program pass
    start_pass(1'b0);
    program_full(8'hF0);
    check("t1_bit_count", 32'(bit_count), 32'd20);
    check("t1_shifts", 32'(shifts), 32'd20);
    check("t1_run_len", 32'(last_cyc - first_cyc + 1), 32'd20);
    check("t1_done_once", 32'(done_seen), 32'd1);
    check("t1_chain", 32'(chain), 32'hA53CF);
    check("t1_error", 32'(error), 32'd0);
    check("t1_queue_empty", 32'(exp_q.size()), 32'd0);

    // 2: source stalls long enough to drain the chain feed
    start_pass(1'b0);
    send_word(8'hA5); send_word(8'h3C);
    word_valid = 1'b0;
    n = 0;
    while (ccff_shift_en && n < 40) begin tick(); n++; end
    check("t2_underrun", 32'(ccff_shift_en), 32'd0);
    check("t2_underrun_count", 32'(bit_count), 32'd16);
    repeat (5) tick();
    check("t2_hold_count", 32'(bit_count), 32'd16);
    send_word(8'hF0);
    word_valid = 1'b0;
    wait_idle();
    check("t2_gap_seen", 32'((last_cyc - first_cyc + 1) > 20), 32'd1);
    check("t2_shifts", 32'(shifts), 32'd20);
    check("t2_chain", 32'(chain), 32'hA53CF);
    check("t2_done_once", 32'(done_seen), 32'd1);

    // 3: verify passes, matching then corrupted
    start_pass(1'b1);
    program_full(8'hF0);
    check("t3_error_clean", 32'(error), 32'd0);
    check("t3_done_once", 32'(done_seen), 32'd1);
    check("t3_chain", 32'(chain), 32'hA53CF);
    start_pass(1'b1);
    send_word(8'hA5); send_word(8'h3D); send_word(8'hF0);
    word_valid = 1'b0;
    wait_count(15);
    check("t3_error_before_bit15", 32'(error), 32'd0);
    tick(); tick();
    check("t3_error_after_bit15", 32'(error), 32'd1);
    wait_idle();
    check("t3_error_sticky", 32'(error), 32'd1);
    check("t3_done_once_bad", 32'(done_seen), 32'd1);

    // 4: abort mid-pass, then restart
    start_pass(1'b0);
    check("t4_error_cleared", 32'(error), 32'd0);
    send_word(8'hA5); send_word(8'h3C);
    word_valid = 1'b0;
    wait_count(9);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_shift_en", 32'(ccff_shift_en), 32'd0);
    exp_q.delete();
    repeat (3) tick();
    check("t4_no_done", 32'(done_seen), 32'd0);
    check("t4_stays_idle", 32'(busy), 32'd0);
    start_pass(1'b0);
    check("t4_restart_count", 32'(bit_count), 32'd0);
    program_full(8'hF0);
    check("t4_done_once", 32'(done_seen), 32'd1);
    check("t4_chain", 32'(chain), 32'hA53CF);

    // 5: start while busy, async reset mid-pass, partial last word
    start_pass(1'b0);
    send_word(8'hA5); send_word(8'h3C);
    word_valid = 1'b0;
    wait_count(5);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t5_start_ignored_count", 32'(bit_count), 32'd6);
    check("t5_start_ignored_busy", 32'(busy), 32'd1);
    prog_reset_n = 1'b0;
    #1;
    check_reset_outputs("t5_async_reset");
    tick();
    prog_reset_n = 1'b1;
    exp_q.delete();
    tick();
    start_pass(1'b0);
    program_full(8'hF7);
    check("t5_bit_count", 32'(bit_count), 32'd20);
    check("t5_shifts", 32'(shifts), 32'd20);
    check("t5_chain_low_bits_dropped", 32'(chain), 32'hA53CF);
    check("t5_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
